// File: rtl/float_seq_alu_if.sv
// rtl/float_seq_alu_if.sv - start/done request bus of the sequential float ALU
interface float_seq_alu_if #(
    parameter int Ne = 8,
    parameter int Nm = 23
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [Ne+Nm:0]   a_i;
    logic [Ne+Nm:0]   b_i;
    logic             busy_o;
    logic             done_o;
    logic [Ne+Nm:0]   result_o;
    logic             ovf_o;
    logic             unf_o;
    logic             inv_o;

    modport master (
        output start_i, op_i, a_i, b_i,
        input  busy_o, done_o, result_o, ovf_o, unf_o, inv_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i,
        output busy_o, done_o, result_o, ovf_o, unf_o, inv_o
    );
endinterface

// File: rtl/float_seq_alu.sv
// rtl/float_seq_alu.sv - multi-cycle add/sub/mul float unit; FLOAT_ROUND_NEAREST_EN selects RNE over truncation
module float_seq_alu #(
    parameter int Ne = 8,
    parameter int Nm = 23
) (
    input  logic           clk_i,
    input  logic           rst_i,
    float_seq_alu_if.slave bus
);
    localparam int W   = Ne + Nm + 1;
    localparam int SW  = Nm + 4;
    localparam int PW  = 2 * Nm + 2;
    localparam int LZW = $clog2(Nm + 5);
    localparam int CW  = $clog2(Nm + 1);
    localparam logic signed [Ne+1:0] EXP_BIAS = (Ne+2)'(2**(Ne-1) - 1);
    localparam logic signed [Ne+1:0] EXP_MAX  = (Ne+2)'(2**Ne - 2);
    localparam logic signed [Ne+1:0] EXP_MIN  = (Ne+2)'(1);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, MUL, NORM, PACK} state_t;

    function automatic logic [Ne-1:0] exp_of(input logic [W-1:0] x);
        return x[W-2:Nm];
    endfunction

    function automatic logic [Nm:0] man_of(input logic [W-1:0] x);
        return (x[W-2:Nm] == '0) ? '0 : {1'b1, x[Nm-1:0]};
    endfunction

    function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
        logic [LZW-1:0] n;
        n = '0;
        for (int i = 0; i < SW; i++) begin
            if (v[i]) n = LZW'(SW - 1 - i);
        end
        return n;
    endfunction

    state_t state_q, state_d;
    logic [1:0]           op_q;
    logic [W-1:0]         a_q, b_q;
    logic                 sign_q, eff_sub_q;
    logic signed [Ne+1:0] exp_q;
    logic [SW-1:0]        big_q, small_q;
    logic [SW:0]          sum_q;
    logic [PW-1:0]        prod_q;
    logic [Nm:0]          mcand_q;
    logic [CW-1:0]        cnt_q;
    logic                 done_q, ovf_q, unf_q, inv_q;
    logic [W-1:0]         result_q;

    assign bus.busy_o   = (state_q != IDLE);
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
    assign bus.ovf_o    = ovf_q;
    assign bus.unf_o    = unf_q;
    assign bus.inv_o    = inv_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    case (bus.op_i)
                        2'b00, 2'b01: state_d = ALIGN;
                        2'b10:        state_d = MUL;
                        default:      state_d = PACK;
                    endcase
                end
            end
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            MUL:     if (cnt_q == CW'(Nm)) state_d = NORM;
            NORM:    state_d = PACK;
            PACK:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Alignment: larger magnitude first, smaller shifted into hidden..sticky
    logic          a_big;
    logic [W-1:0]  big_x, small_x;
    logic [Ne-1:0] diff;
    logic [SW-1:0] small_raw, small_al;

    always_comb begin
        a_big     = {exp_of(a_q), man_of(a_q)} >= {exp_of(b_q), man_of(b_q)};
        big_x     = a_big ? a_q : b_q;
        small_x   = a_big ? b_q : a_q;
        diff      = exp_of(big_x) - exp_of(small_x);
        small_raw = {man_of(small_x), 3'b000};
        if (diff > Ne'(Nm + 3))
            small_al = {{(SW-1){1'b0}}, |small_raw};
        else
            small_al = (small_raw >> diff)
                     | {{(SW-1){1'b0}}, |(small_raw & ~({SW{1'b1}} << diff))};
    end

    logic [Nm+1:0] psum;
    assign psum = {1'b0, prod_q[PW-1:Nm+1]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

    logic [SW:0]          norm_in, norm_sig;
    logic [LZW-1:0]       lz;
    logic signed [Ne+1:0] norm_exp;

    always_comb begin
        norm_in = (op_q == 2'b10) ? {prod_q[PW-1:Nm-2], |prod_q[Nm-3:0]} : sum_q;
        lz      = lzc(norm_in[SW-1:0]);
        if (norm_in[SW]) begin
            norm_sig = {1'b0, norm_in[SW:2], norm_in[1] | norm_in[0]};
            norm_exp = exp_q + (Ne+2)'(1);
        end else begin
            norm_sig = norm_in << lz;
            norm_exp = exp_q - $signed({{(Ne+2-LZW){1'b0}}, lz});
        end
    end

    logic                 round_up;
    logic [Nm+1:0]        mant_r;
    logic signed [Ne+1:0] exp_r;
    logic [W-1:0]         pack_res;
    logic                 pack_ovf, pack_unf, pack_inv;

    always_comb begin
`ifdef FLOAT_ROUND_NEAREST_EN
        round_up = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
`else
        round_up = 1'b0;
`endif
        mant_r   = {1'b0, sum_q[SW-1:3]} + (Nm+2)'(round_up);
        exp_r    = exp_q + $signed({{(Ne+1){1'b0}}, mant_r[Nm+1]});
        pack_res = '0;
        pack_ovf = 1'b0;
        pack_unf = 1'b0;
        pack_inv = 1'b0;
        if (op_q == 2'b11) begin
            pack_inv = 1'b1;
        end else if (mant_r[Nm+1:Nm] == 2'b00) begin
            pack_res = '0;
        end else if (exp_r > EXP_MAX) begin
            pack_res = {sign_q, Ne'(2**Ne - 2), {Nm{1'b1}}};
            pack_ovf = 1'b1;
        end else if (exp_r < EXP_MIN) begin
            pack_res = {sign_q, {(W-1){1'b0}}};
            pack_unf = 1'b1;
        end else begin
            // on a rounding carry the low Nm bits of mant_r are already zero
            pack_res = {sign_q, exp_r[Ne-1:0], mant_r[Nm-1:0]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            exp_q     <= '0;
            big_q     <= '0;
            small_q   <= '0;
            sum_q     <= '0;
            prod_q    <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            done_q <= (state_q == PACK);
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        op_q    <= bus.op_i;
                        a_q     <= bus.a_i;
                        b_q     <= {bus.b_i[W-1] ^ (bus.op_i == 2'b01), bus.b_i[W-2:0]};
                        sign_q  <= bus.a_i[W-1] ^ bus.b_i[W-1];
                        exp_q   <= $signed({2'b00, exp_of(bus.a_i)})
                                 + $signed({2'b00, exp_of(bus.b_i)}) - EXP_BIAS;
                        mcand_q <= man_of(bus.a_i);
                        prod_q  <= {{(Nm+1){1'b0}}, man_of(bus.b_i)};
                        cnt_q   <= '0;
                    end
                end
                ALIGN: begin
                    big_q     <= {man_of(big_x), 3'b000};
                    small_q   <= small_al;
                    exp_q     <= $signed({2'b00, exp_of(big_x)});
                    sign_q    <= big_x[W-1];
                    eff_sub_q <= a_q[W-1] ^ b_q[W-1];
                end
                ADD: begin
                    sum_q <= eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                       : ({1'b0, big_q} + {1'b0, small_q});
                end
                MUL: begin
                    prod_q <= {psum, prod_q[Nm:1]};
                    cnt_q  <= cnt_q + CW'(1);
                end
                NORM: begin
                    sum_q <= norm_sig;
                    exp_q <= norm_exp;
                end
                PACK: begin
                    result_q <= pack_res;
                    ovf_q    <= pack_ovf;
                    unf_q    <= pack_unf;
                    inv_q    <= pack_inv;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_float_seq_alu.sv
// tb/tb_float_seq_alu.sv - directed self-checking bench for float_seq_alu
module tb_float_seq_alu;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    float_seq_alu_if #(.Ne(8), .Nm(23)) bus ();

    float_seq_alu #(.Ne(8), .Nm(23)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Called at a negedge with busy low; returns at the negedge of the done cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic [2:0] fl);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.op_i    = ~op;
        bus.a_i     = ~a;
        bus.b_i     = ~b;
        lat = 0;
        forever begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.done_o) break;
            if (lat >= 200) begin lat = -1; break; end
        end
        res = bus.result_o;
        fl  = {bus.ovf_o, bus.unf_o, bus.inv_o};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0; bus.op_i = 2'b00; bus.a_i = '0; bus.b_i = '0;
        repeat (3) @(negedge clk);
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
        total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus.done_o); end
        total++; if (bus.result_o !== 32'h0) begin bad++; $display("FAIL reset_result got %h want 0", bus.result_o); end
        total++; if ({bus.ovf_o, bus.unf_o, bus.inv_o} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", {bus.ovf_o, bus.unf_o, bus.inv_o}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        int lat; logic [31:0] res; logic [2:0] fl;
        run_op(2'b00, 32'h3FC00000, 32'h40100000, lat, res, fl);
        total++; if (lat !== 4) begin bad++; $display("FAIL add_latency got %0d want 4", lat); end
        total++; if (res !== 32'h40700000) begin bad++; $display("FAIL add_result got %h want 40700000", res); end
        total++; if (fl !== 3'b000) begin bad++; $display("FAIL add_flags got %b want 000", fl); end
        run_op(2'b00, 32'h40400000, 32'hC0800000, lat, res, fl);
        total++; if (res !== 32'hBF800000) begin bad++; $display("FAIL add_mixed_sign got %h want bf800000", res); end
        run_op(2'b01, 32'h3FC00000, 32'hBFC00000, lat, res, fl);
        total++; if (res !== 32'h40400000) begin bad++; $display("FAIL sub_carry got %h want 40400000", res); end
        total++; if (lat !== 4) begin bad++; $display("FAIL sub_latency got %0d want 4", lat); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] res; logic [2:0] fl;
        run_op(2'b10, 32'h40400000, 32'hC0000000, lat, res, fl);
        total++; if (lat !== 26) begin bad++; $display("FAIL mul_latency got %0d want 26", lat); end
        total++; if (res !== 32'hC0C00000) begin bad++; $display("FAIL mul_result got %h want c0c00000", res); end
        total++; if (fl !== 3'b000) begin bad++; $display("FAIL mul_flags got %b want 000", fl); end
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL done_cycle_busy got %b want 0", bus.busy_o); end
        run_op(2'b00, 32'h3FC00000, 32'h40100000, lat, res, fl);
        total++; if (lat !== 4) begin bad++; $display("FAIL b2b_latency got %0d want 4", lat); end
        total++; if (res !== 32'h40700000) begin bad++; $display("FAIL b2b_result got %h want 40700000", res); end
    endtask

    task automatic test_reserved();
        int lat; logic [31:0] res; logic [2:0] fl;
        run_op(2'b11, 32'h40400000, 32'h40400000, lat, res, fl);
        total++; if (lat !== 1) begin bad++; $display("FAIL rsv_latency got %0d want 1", lat); end
        total++; if (res !== 32'h0) begin bad++; $display("FAIL rsv_result got %h want 0", res); end
        total++; if (fl !== 3'b001) begin bad++; $display("FAIL rsv_flags got %b want 001", fl); end
    endtask

    task automatic test_ignored_start();
        int dones = 0; int lat = -1; int gap = 0;
        logic [31:0] res = 32'hDEADBEEF; logic [2:0] fl = 3'b111;
        bus.start_i = 1'b1; bus.op_i = 2'b01; bus.a_i = 32'h3F800000; bus.b_i = 32'h3F800000;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0; bus.op_i = 2'b10; bus.a_i = 32'h40400000; bus.b_i = 32'h40400000;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done_o) begin
                dones++;
                if (dones == 1) begin lat = k; res = bus.result_o; fl = {bus.ovf_o, bus.unf_o, bus.inv_o}; end
            end else if (!bus.busy_o && dones == 0) gap++;
            bus.start_i = (k == 2);
        end
        bus.start_i = 1'b0;
        total++; if (dones !== 1) begin bad++; $display("FAIL ign_done_count got %0d want 1", dones); end
        total++; if (lat !== 4) begin bad++; $display("FAIL ign_latency got %0d want 4", lat); end
        total++; if (gap !== 0) begin bad++; $display("FAIL ign_busy_gap got %0d want 0", gap); end
        total++; if (res !== 32'h0) begin bad++; $display("FAIL cancel_result got %h want 0", res); end
        total++; if (fl !== 3'b000) begin bad++; $display("FAIL cancel_flags got %b want 000", fl); end
    endtask

    task automatic test_range();
        int lat; logic [31:0] res; logic [2:0] fl;
        run_op(2'b10, 32'h7F000000, 32'h7F000000, lat, res, fl);
        total++; if (res !== 32'h7F7FFFFF) begin bad++; $display("FAIL ovf_result got %h want 7f7fffff", res); end
        total++; if (fl !== 3'b100) begin bad++; $display("FAIL ovf_flags got %b want 100", fl); end
        run_op(2'b10, 32'h00800000, 32'h00800000, lat, res, fl);
        total++; if (res !== 32'h0) begin bad++; $display("FAIL unf_result got %h want 0", res); end
        total++; if (fl !== 3'b010) begin bad++; $display("FAIL unf_flags got %b want 010", fl); end
        run_op(2'b10, 32'h00000000, 32'h40400000, lat, res, fl);
        total++; if (res !== 32'h0) begin bad++; $display("FAIL mulzero_result got %h want 0", res); end
        total++; if (lat !== 26) begin bad++; $display("FAIL mulzero_latency got %0d want 26", lat); end
        total++; if (fl !== 3'b000) begin bad++; $display("FAIL mulzero_flags got %b want 000", fl); end
    endtask

    task automatic test_rounding();
        int lat; logic [31:0] res; logic [2:0] fl; logic [31:0] want;
`ifdef FLOAT_ROUND_NEAREST_EN
        want = 32'h3F800001;
`else
        want = 32'h3F800000;
`endif
        run_op(2'b00, 32'h3F800000, 32'h33C00000, lat, res, fl);
        total++; if (res !== want) begin bad++; $display("FAIL round_above_half got %h want %h", res, want); end
        run_op(2'b00, 32'h3F800000, 32'h33800000, lat, res, fl);
        total++; if (res !== 32'h3F800000) begin bad++; $display("FAIL round_tie got %h want 3f800000", res); end
        total++; if (lat !== 4) begin bad++; $display("FAIL round_latency got %0d want 4", lat); end
    endtask

    task automatic test_reset_mid_mul();
        int lat; logic [31:0] res; logic [2:0] fl; int dones = 0;
        run_op(2'b10, 32'h40400000, 32'hC0000000, lat, res, fl);
        bus.start_i = 1'b1; bus.op_i = 2'b10; bus.a_i = 32'h40400000; bus.b_i = 32'h40400000;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_busy got %b want 0", bus.busy_o); end
        total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL rstmid_done got %b want 0", bus.done_o); end
        total++; if (bus.result_o !== 32'h0) begin bad++; $display("FAIL rstmid_result got %h want 0", bus.result_o); end
        total++; if ({bus.ovf_o, bus.unf_o, bus.inv_o} !== 3'b000) begin bad++; $display("FAIL rstmid_flags got %b want 000", {bus.ovf_o, bus.unf_o, bus.inv_o}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done_o || bus.busy_o) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL rstmid_activity got %0d want 0", dones); end
        run_op(2'b00, 32'h3FC00000, 32'h40100000, lat, res, fl);
        total++; if (res !== 32'h40700000) begin bad++; $display("FAIL rstmid_next_result got %h want 40700000", res); end
        total++; if (lat !== 4) begin bad++; $display("FAIL rstmid_next_latency got %0d want 4", lat); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_reserved();
        test_ignored_start();
        test_range();
        test_rounding();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/float_seq_alu.md
# float_seq_alu

Multi-cycle, parametrised floating-point arithmetic unit for the LM32 coprocessor. Performs add, sub and mul on operands in the team float format (sign, Ne-bit biased exponent, Nm-bit mantissa with hidden one) using a start/done handshake. Add/sub uses a short fixed pipeline of states; mul uses an iterative shift-add multiplier. It is instantiated behind the coprocessor register interface and replaces the combinational package functions in the synthesised datapath.

## Interface
- Ne, 8, exponent width; bias = 2^(Ne-1)-1
- Nm, 23, stored mantissa width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  request; accepted only when busy_o=0
- op_i  in  2  00 add, 01 sub (a-b), 10 mul, 11 reserved
- a_i, b_i  in  Ne+Nm+1 each  operands, latched on accept
- busy_o  out  1  high from the accept edge until the edge that raises done_o
- done_o  out  1  one-cycle pulse; result and flags valid
- result_o  out  Ne+Nm+1  result; held until the next done_o
- ovf_o, unf_o, inv_o  out  1 each  overflow-saturated, underflow-flushed, reserved-op flags; updated with done_o

## Operation
- All outputs reset to 0. The FSM resets to IDLE.
- FSM states: IDLE, ALIGN, ADD, MUL, NORM, PACK.
- IDLE with start_i=1:
  - add/sub goes to ALIGN.
  - mul goes to MUL.
  - op 11 goes to PACK with result 0 and inv_o=1.
- Format rules:
  - An exponent field of 0 means zero (hidden bit 0) regardless of the mantissa.
  - No inf/NaN. An input exponent of 2^Ne-1 is treated as finite.
  - Outputs never use exponent 2^Ne-1.
- Sub is add with the sign of b inverted.
- ALIGN:
  - Swap the operands so the larger magnitude (exponent, then mantissa) is first.
  - Shift the smaller significand right by the exponent difference, into a working width of Nm+4 (hidden, Nm, guard, round, sticky). Shifted-out bits OR into sticky.
  - A difference greater than Nm+3 leaves sticky only.
- ADD: add or subtract the significands according to the effective sign. The result sign is the sign of the larger operand.
- MUL:
  - Nm+1 cycles of shift-add on (Nm+1)x(Nm+1) significands, giving a 2Nm+2-bit product.
  - Sign = sa xor sb.
  - Exponent = ea+eb-bias, computed in an Ne+2-bit signed field.
  - A zero operand forces a zero result, but the cycle count is unchanged.
- NORM:
  - Leading-one detect and shift in one cycle.
  - Carry-out: shift right 1 and add 1 to the exponent.
  - Otherwise shift left by the leading-zero count and subtract it from the exponent.
- PACK: round (see Configuration), then range check and pack.
  - Zero significand (exact cancellation): +0, no flags.
  - Biased exponent > 2^Ne-2: saturate to exponent 2^Ne-2 with mantissa all ones, keep the sign, ovf_o=1.
  - Biased exponent < 1: signed zero, unf_o=1.
  - Rounding carry-out renormalises and is re-checked for overflow.

## Timing
- Accept edge = edge 0, at which start_i=1 and busy_o=0 are sampled.
- Add/sub: ALIGN, ADD, NORM, PACK. done_o is high in the cycle after edge 4, so latency is 4.
- Mul: MUL for Nm+1 cycles, then NORM, then PACK. done_o follows edge Nm+3 (26 at default).
- Reserved op: done_o follows edge 1.
- done_o cycle: busy_o=0, so a start_i in that cycle is accepted (back-to-back, no bubble).
- start_i while busy_o=1 is ignored. It is not queued and has no effect on the operands in flight.
- a_i, b_i and op_i may change after the accept edge.
- rst_i mid-operation: immediate return to IDLE, all outputs 0, no done_o for the aborted op.

## Configuration
- FLOAT_ROUND_NEAREST_EN:
  - Defined: PACK rounds to nearest, ties to even, using guard/round/sticky.
  - Undefined: PACK truncates, and the guard/round/sticky logic is removed.
- Latency is identical in both builds.

## Test plan
- Add: a=0x3FC00000 (1.5), b=0x40100000 (2.25) -> result 0x40700000, done_o exactly 4 cycles after accept, flags 0.
- Mul with back-to-back accept: a=0x40400000, b=0xC0000000 -> result 0xC0C00000 after 26 cycles. A new start in the done cycle is accepted.
- Sub cancellation and ignored start: 0x3F800000 - 0x3F800000 -> 0x00000000. A start_i pulsed mid-operation is ignored: exactly one done_o, busy_o continuous.
- Overflow and underflow:
  - 0x7F000000 * 0x7F000000 -> 0x7F7FFFFF, ovf_o=1.
  - 0x00800000 * 0x00800000 -> 0x00000000, unf_o=1.
- Rounding: 0x3F800000 + 0x33C00000 -> 0x3F800001 with FLOAT_ROUND_NEAREST_EN, 0x3F800000 without. 0x3F800000 + 0x33800000 (tie) -> 0x3F800000 in both builds.
- Reset mid-mul: assert rst_i 10 cycles after accept -> busy_o, done_o, result_o and flags all 0 immediately. The next add completes normally.
